dhcp_sequencer: RTL
===================

# dhcp_sequencer

Top-level scheduler for the DHCP helper. After reset it sequences the network-parameter bring-up:
- EEPROM default load;
- link wait;
- DHCP DISCOVER transmit;
- OFFER wait with timeout and exponential backoff retry;
- OFFER parse;
- final BOUND or FAIL status.

It drives the helper's three start/finished handshakes and sits between the board control logic and the DHCP helper / UDP path.

## Interface
- `OFFER_TIMEOUT`, default 32'd12_500_000: base OFFER wait in clk cycles.
- `MAX_RETRIES`, default 4: DISCOVER retransmissions before FAIL.
- `HS_TIMEOUT`, default 32'd65_536: watchdog on any handshake phase.
- `RENEW_CYCLES`, default 32'hFFFF_FFFF: BOUND dwell before rediscovery. Used only with the renew macro.
- `clk  in  1`: system clock.
- `rst_n  in  1`: synchronous reset, active-low.
- `enable  in  1`: run sequencer. Low returns to IDLE at the next safe point.
- `link_up  in  1`: PHY link status, already synchronised.
- `eeprom_start  out  1` / `eeprom_finished  in  1`: EEPROM load handshake.
- `discover_start  out  1` / `discover_finished  in  1`: DISCOVER build handshake.
- `offer_rx  in  1`: 1-cycle pulse, OFFER frame arriving at the UDP demux.
- `offer_start  out  1` / `offer_finished  in  1`: OFFER parse handshake.
- `offer_ok  in  1`: parse result, sampled in the cycle `offer_finished` is first seen high.
- `bound  out  1`: parameters valid from DHCP.
- `fail  out  1`: retries or watchdog exhausted.
- `retry_cnt  out  $clog2(MAX_RETRIES+1)`: current retry index.
- `busy  out  1`: high in every state except IDLE, BOUND and FAIL.

## Operation
- **Reset values:** all outputs 0; state IDLE; timer 0.
- **Handshake protocol (four-phase), for each operation X:**
  - REQ state: drive X_start=1 until X_finished=1.
  - REL state: drive X_start=0 until X_finished=0.
  - The next start is never raised while any finished is high.
- **State transitions:**
  - IDLE: enable → EE_REQ.
  - EE_REQ → EE_REL → LINK_WAIT.
  - LINK_WAIT: link_up → DISC_REQ, with retry_cnt=0.
  - DISC_REQ → DISC_REL → OFFER_WAIT. The timer is loaded with `OFFER_TIMEOUT << retry_cnt`, saturated to 32'hFFFF_FFFF.
  - OFFER_WAIT:
    - offer_rx → OFF_REQ.
    - Timer reaches 0 → BACKOFF.
  - OFF_REQ → OFF_REL, then:
    - offer_ok=1 → BOUND.
    - offer_ok=0 → OFFER_WAIT, with the remaining timer preserved.
  - BACKOFF (1 cycle):
    - retry_cnt==MAX_RETRIES → FAIL.
    - Otherwise retry_cnt+1 → DISC_REQ.
  - BOUND: bound=1. enable=0 → IDLE.
  - FAIL: fail=1. enable=0 → IDLE. A pulse of enable restarts from EE_REQ.
- **Watchdog:** a second counter reloads with HS_TIMEOUT on entry to each REQ/REL state. If it expires → FAIL, and all start outputs drop in the same cycle.
- **Boundaries and simultaneous events:**
  - offer_rx in the same cycle the timer reaches 0: offer wins.
  - link_up falls in LINK_WAIT or OFFER_WAIT → LINK_WAIT. retry_cnt is not cleared.
  - link_up falls in REQ/REL: the handshake is completed first, then → LINK_WAIT. A helper mid-frame is never aborted.
  - enable falls mid-handshake: completes the REL phase, then → IDLE.
  - offer_rx outside OFFER_WAIT is ignored.
  - rst_n low in any state → IDLE on the next edge; all start outputs 0.
- **Arithmetic:** the shift is done on 32-bit values with overflow detection; retry_cnt saturates at MAX_RETRIES.

## Timing
- All outputs are registered.
- X_start rises 1 cycle after entry to X_REQ.
- finished seen high → X_start low on the next edge.
- OFFER_WAIT expires exactly `OFFER_TIMEOUT<<retry_cnt` cycles after entry.
- bound/fail assert 1 cycle after the deciding handshake completes.
- The minimum EE_REQ→DISC_REQ path with link_up already high is 4 cycles plus helper latency.

## Configuration
- **`DHCP_SEQ_RENEW_EN` defined:**
  - In BOUND, a counter runs RENEW_CYCLES.
  - On expiry: bound=0, retry_cnt=0 → DISC_REQ.
  - link_up falling in BOUND → LINK_WAIT, with bound=0.
- **Undefined:** BOUND is terminal until enable=0. link_up is ignored in BOUND, and no renew counter is synthesised.

## Structure
- **`dhcp_pkg`:**
  - `dhcp_seq_state_t` enum: IDLE, EE_REQ, EE_REL, LINK_WAIT, DISC_REQ, DISC_REL, OFFER_WAIT, OFF_REQ, OFF_REL, BACKOFF, BOUND, FAIL.
  - Shared default timeout constants.
- **`dhcp_backoff_timer` sub-module:**
  - Inputs: load, base, shift.
  - Behaviour: saturating shift and down-count.
  - Outputs: `expired` pulse and `remaining`.
  - Also reused for the watchdog.

## Test plan
1. **Nominal bind.** OFFER_TIMEOUT=100, MAX_RETRIES=3, HS_TIMEOUT=1000. enable=1, link_up=1, helper model finishes each handshake after 5 cycles, offer_rx at cycle 40 of OFFER_WAIT, offer_ok=1 → bound=1, fail=0, retry_cnt=0. Every start stays high until its finished, and no two starts overlap.
2. **No offer.** Never pulse offer_rx → DISCOVER sent 4 times, with OFFER_WAIT lengths 100/200/400/800 cycles, then fail=1 with retry_cnt=3.
3. **Bad offer then good offer.**
   - offer_ok=0 at cycle 30 → returns to OFFER_WAIT and expires at cycle 100 from the original entry.
   - On a rerun, a second offer at cycle 60 with offer_ok=1 → bound=1.
4. **Simultaneous events.** offer_rx on the exact expiry cycle → OFF_REQ is entered, not BACKOFF.
5. **Link drop during handshake.** Drop link_up during DISC_REQ → discover handshake completes, then LINK_WAIT. Link restores → DISC_REQ with retry_cnt unchanged.
6. **Watchdog and reset.**
   - eeprom_finished held 0 → fail=1 after 1000 cycles, with eeprom_start=0.
   - rst_n=0 mid-OFFER_WAIT → all outputs 0 on the next edge.

Source files
------------

// File: rtl/dhcp_pkg.sv
// Shared types and default timing constants for the DHCP helper sequencer.
package dhcp_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    EE_REQ     = 4'd1,
    EE_REL     = 4'd2,
    LINK_WAIT  = 4'd3,
    DISC_REQ   = 4'd4,
    DISC_REL   = 4'd5,
    OFFER_WAIT = 4'd6,
    OFF_REQ    = 4'd7,
    OFF_REL    = 4'd8,
    BACKOFF    = 4'd9,
    BOUND      = 4'd10,
    FAIL       = 4'd11
  } dhcp_seq_state_t;

  localparam logic [31:0] DEF_OFFER_TIMEOUT = 32'd12_500_000;
  localparam int          DEF_MAX_RETRIES   = 4;
  localparam logic [31:0] DEF_HS_TIMEOUT    = 32'd65_536;
  localparam logic [31:0] DEF_RENEW_CYCLES  = 32'hFFFF_FFFF;

  // REQ/REL states are the ones guarded by the handshake watchdog.
  function automatic logic is_hs(dhcp_seq_state_t s);
    return (s == EE_REQ) || (s == EE_REL) || (s == DISC_REQ) ||
           (s == DISC_REL) || (s == OFF_REQ) || (s == OFF_REL);
  endfunction

endpackage

// File: rtl/dhcp_backoff_timer.sv
// Loadable down-counter: load value is base << shift saturated to 32 bits,
// counts down while run is high and stops at zero.
module dhcp_backoff_timer #(
  parameter int SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               run,
  input  logic [31:0]        base,
  input  logic [SHIFT_W-1:0] shift,
  output logic               expired,
  output logic [31:0]        remaining
);

  logic [31:0] remaining_q, remaining_d;
  logic [63:0] wide;
  logic        overflow;
  logic [31:0] load_val;

  always_comb begin
    wide        = {32'd0, base} << shift;
    overflow    = (base != 32'd0) &&
                  ((32'(shift) > 32'd31) || (wide[63:32] != 32'd0));
    load_val    = overflow ? 32'hFFFF_FFFF : wide[31:0];
    remaining_d = remaining_q;
    if (load) begin
      remaining_d = load_val;
    end else if (run && (remaining_q != 32'd0)) begin
      remaining_d = remaining_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining_q <= 32'd0;
    end else begin
      remaining_q <= remaining_d;
    end
  end

  // High in the cycle whose closing edge takes the count to zero.
  assign expired   = run && (remaining_q == 32'd1);
  assign remaining = remaining_q;

endmodule

// File: rtl/dhcp_sequencer.sv
// DHCP bring-up scheduler: EEPROM load, link wait, DISCOVER/OFFER with backoff.
// Optional BOUND renewal and link-loss handling under DHCP_SEQ_RENEW_EN.
module dhcp_sequencer
  import dhcp_pkg::*;
#(
  parameter logic [31:0] OFFER_TIMEOUT = DEF_OFFER_TIMEOUT,
  parameter int          MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter logic [31:0] HS_TIMEOUT    = DEF_HS_TIMEOUT,
  parameter logic [31:0] RENEW_CYCLES  = DEF_RENEW_CYCLES,
  localparam int         RETRY_W       = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               link_up,
  output logic               eeprom_start,
  input  logic               eeprom_finished,
  output logic               discover_start,
  input  logic               discover_finished,
  input  logic               offer_rx,
  output logic               offer_start,
  input  logic               offer_finished,
  input  logic               offer_ok,
  output logic               bound,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               busy,
  output logic [3:0]         state_dbg
);

  // Four-phase handshake: X_start is held high until X_finished is seen high,
  // then held low until X_finished is seen low; only then may any start rise.
  dhcp_seq_state_t    state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic stop_q, stop_d, link_lost_q, link_lost_d, ok_q, ok_d;
  logic ee_start_q, ee_start_d, disc_start_q, disc_start_d, off_start_q, off_start_d;
  logic bound_q, bound_d, fail_q, fail_d, busy_q, busy_d;

  logic        ofr_load, ofr_run, ofr_expired;
  logic [31:0] ofr_rem;
  logic        wdg_load, wdg_run, wdg_expired;
  logic [31:0] wdg_rem_unused;
  logic        ofr_done;

  dhcp_backoff_timer #(.SHIFT_W(RETRY_W)) u_offer_timer (
    .clk(clk), .rst_n(rst_n), .load(ofr_load), .run(ofr_run),
    .base(OFFER_TIMEOUT), .shift(retry_q),
    .expired(ofr_expired), .remaining(ofr_rem)
  );

  dhcp_backoff_timer #(.SHIFT_W(1)) u_watchdog (
    .clk(clk), .rst_n(rst_n), .load(wdg_load), .run(wdg_run),
    .base(HS_TIMEOUT), .shift(1'b0),
    .expired(wdg_expired), .remaining(wdg_rem_unused)
  );

`ifdef DHCP_SEQ_RENEW_EN
  logic        renew_load, renew_run, renew_expired;
  logic [31:0] renew_rem_unused;

  dhcp_backoff_timer #(.SHIFT_W(1)) u_renew_timer (
    .clk(clk), .rst_n(rst_n), .load(renew_load), .run(renew_run),
    .base(RENEW_CYCLES), .shift(1'b0),
    .expired(renew_expired), .remaining(renew_rem_unused)
  );

  assign renew_load = (state_d == BOUND) && (state_q != BOUND);
  assign renew_run  = (state_q == BOUND);
`else
  logic unused_renew;
  assign unused_renew = ^RENEW_CYCLES;
`endif

  assign ofr_done = ofr_expired || (ofr_rem == 32'd0);

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    ok_d        = ok_q;
    // Abort requests seen mid-handshake are remembered until the REL phase ends.
    stop_d      = is_hs(state_q) && (stop_q || !enable);
    link_lost_d = is_hs(state_q) && (link_lost_q || !link_up);

    unique case (state_q)
      IDLE: if (enable) state_d = EE_REQ;
      EE_REQ: begin
        if (eeprom_finished)  state_d = EE_REL;
        else if (wdg_expired) state_d = FAIL;
      end
      EE_REL: begin
        if (!eeprom_finished) state_d = stop_d ? IDLE : LINK_WAIT;
        else if (wdg_expired) state_d = FAIL;
      end
      LINK_WAIT: begin
        if (!enable)      state_d = IDLE;
        else if (link_up) state_d = DISC_REQ;
      end
      DISC_REQ: begin
        if (discover_finished) state_d = DISC_REL;
        else if (wdg_expired)  state_d = FAIL;
      end
      DISC_REL: begin
        if (!discover_finished) begin
          if (stop_d)           state_d = IDLE;
          else if (link_lost_d) state_d = LINK_WAIT;
          else                  state_d = OFFER_WAIT;
        end else if (wdg_expired) begin
          state_d = FAIL;
        end
      end
      OFFER_WAIT: begin
        if (!enable)       state_d = IDLE;
        else if (!link_up) state_d = LINK_WAIT;
        else if (offer_rx) state_d = OFF_REQ;
        else if (ofr_done) state_d = BACKOFF;
      end
      OFF_REQ: begin
        if (offer_finished) begin
          state_d = OFF_REL;
          ok_d    = offer_ok;
        end else if (wdg_expired) begin
          state_d = FAIL;
        end
      end
      OFF_REL: begin
        // The OFFER timer keeps running through the parse, so a rejected
        // offer resumes the original wait rather than restarting it.
        if (!offer_finished) begin
          if (stop_d)           state_d = IDLE;
          else if (link_lost_d) state_d = LINK_WAIT;
          else if (ok_q)        state_d = BOUND;
          else if (ofr_done)    state_d = BACKOFF;
          else                  state_d = OFFER_WAIT;
        end else if (wdg_expired) begin
          state_d = FAIL;
        end
      end
      BACKOFF: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (retry_q == RETRY_W'(MAX_RETRIES)) begin
          state_d = FAIL;
        end else begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = DISC_REQ;
        end
      end
      BOUND: begin
        if (!enable) begin
          state_d = IDLE;
`ifdef DHCP_SEQ_RENEW_EN
        end else if (!link_up) begin
          state_d = LINK_WAIT;
        end else if (renew_expired) begin
          retry_d = '0;
          state_d = DISC_REQ;
`endif
        end
      end
      FAIL: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_d == EE_REQ) && (state_q != EE_REQ)) retry_d = '0;
  end

  always_comb begin
    ee_start_d   = (state_q == EE_REQ)   && (state_d == EE_REQ);
    disc_start_d = (state_q == DISC_REQ) && (state_d == DISC_REQ);
    off_start_d  = (state_q == OFF_REQ)  && (state_d == OFF_REQ);
    bound_d      = (state_d == BOUND);
    fail_d       = (state_d == FAIL);
    busy_d       = !((state_d == IDLE) || (state_d == BOUND) || (state_d == FAIL));
    ofr_load     = (state_q == DISC_REL) && (state_d == OFFER_WAIT);
    ofr_run      = (state_q == OFFER_WAIT) || (state_q == OFF_REQ) || (state_q == OFF_REL);
    wdg_load     = is_hs(state_d) && (state_d != state_q);
    wdg_run      = is_hs(state_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      retry_q      <= '0;
      stop_q       <= 1'b0;
      link_lost_q  <= 1'b0;
      ok_q         <= 1'b0;
      ee_start_q   <= 1'b0;
      disc_start_q <= 1'b0;
      off_start_q  <= 1'b0;
      bound_q      <= 1'b0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      stop_q       <= stop_d;
      link_lost_q  <= link_lost_d;
      ok_q         <= ok_d;
      ee_start_q   <= ee_start_d;
      disc_start_q <= disc_start_d;
      off_start_q  <= off_start_d;
      bound_q      <= bound_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
    end
  end

  assign eeprom_start   = ee_start_q;
  assign discover_start = disc_start_q;
  assign offer_start    = off_start_q;
  assign bound          = bound_q;
  assign fail           = fail_q;
  assign busy           = busy_q;
  assign retry_cnt      = retry_q;
  assign state_dbg      = state_q;

endmodule
